// File: rtl/tt_um_ccollatz_sergiooliveros_if.sv
// Pin bundle for the Collatz step counter tile.
// Signals:
//   ena     tile enable (ignored by the design)
//   ui_in   start value N
//   uio_in  unused bidirectional inputs
//   uo_out  status: bit0 busy, bit1 done, bits7:2 zero
//   uio_out step count C
//   uio_oe  output enables for the uio pins
// master: drives the tile inputs (harness / testbench side).
// slave:  the tile itself.
interface tt_um_ccollatz_sergiooliveros_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_ccollatz_sergiooliveros.sv
// Collatz step counter. Releasing rst_n loads N from ui_in and counts the
// steps needed to reach 1, one step per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; its release starts a computation
//   bus    pin bundle (slave side): ui_in = N, uo_out = {6'b0, done, busy},
//          uio_out = step count, uio_oe = 8'hFF; ena and uio_in are ignored
module tt_um_ccollatz_sergiooliveros (
    input logic                            clk,
    input logic                            rst_n,
    tt_um_ccollatz_sergiooliveros_if.slave bus
);

    typedef enum logic [1:0] {
        StLoad = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [7:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] n_next;

    // Peak trajectory for any 8-bit start is 13120, so 16 bits never overflow.
    always_comb begin
        if (n_q[0]) begin
            n_next = (n_q << 1) + n_q + 16'd1;
        end else begin
            n_next = n_q >> 1;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            StLoad: begin
                n_d     = {8'd0, bus.ui_in};
                count_d = 8'd0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                state_d = StRun;
            end
            StRun: begin
                // A start value of 0 is treated like 1: finished immediately.
                if (n_q > 16'd1) begin
                    n_d     = n_next;
                    count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StLoad;
            n_q     <= 16'd0;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from flops; no input reaches an output combinationally.
    assign bus.uo_out  = {6'd0, done_q, busy_q};
    assign bus.uio_out = count_q;
    assign bus.uio_oe  = 8'hFF;

    logic unused_inputs;
    assign unused_inputs = ^{bus.ena, bus.uio_in};

endmodule

// File: tb/tb_tt_um_ccollatz_sergiooliveros.sv
module tb_tt_um_ccollatz_sergiooliveros;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    tt_um_ccollatz_sergiooliveros_if bus ();

    tt_um_ccollatz_sergiooliveros dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle reset pulse with N presented; checks the reset outputs.
    task automatic do_reset(input string tag, input logic [7:0] nval);
        @(negedge clk);
        bus.ui_in = nval;
        rst_n     = 1'b0;
        @(negedge clk);
        check({tag, "_rst_uo"}, {24'd0, bus.uo_out}, 32'd0);
        check({tag, "_rst_uio"}, {24'd0, bus.uio_out}, 32'd0);
        check({tag, "_rst_oe"}, {24'd0, bus.uio_oe}, 32'hFF);
        rst_n = 1'b1;
    endtask

    // Follows a computation already released from reset until done.
    task automatic measure(input string tag, input int exp_c, input bit toggle);
        int busy_cycles;
        bit oe_ok;
        bit finished;
        busy_cycles = 0;
        oe_ok       = 1'b1;
        finished    = 1'b0;
        for (int i = 0; i < 400 && !finished; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check({tag, "_first_uo"}, {24'd0, bus.uo_out}, 32'd1);
                check({tag, "_first_cnt"}, {24'd0, bus.uio_out}, 32'd0);
            end
            if (bus.uo_out[0]) busy_cycles++;
            if (bus.uio_oe !== 8'hFF) oe_ok = 1'b0;
            if (bus.uo_out[1]) finished = 1'b1;
            if (toggle) bus.ui_in = 8'($urandom);
        end
        check({tag, "_finished"}, {31'd0, finished}, 32'd1);
        check({tag, "_busy_cycles"}, busy_cycles, exp_c + 1);
        check({tag, "_uo"}, {24'd0, bus.uo_out}, 32'd2);
        check({tag, "_count"}, {24'd0, bus.uio_out}, exp_c);
        check({tag, "_oe"}, {31'd0, oe_ok}, 32'd1);
        // DONE must hold regardless of ui_in.
        repeat (3) begin
            @(negedge clk);
            bus.ui_in = ~bus.ui_in;
        end
        @(negedge clk);
        check({tag, "_hold_uo"}, {24'd0, bus.uo_out}, 32'd2);
        check({tag, "_hold_count"}, {24'd0, bus.uio_out}, exp_c);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'd0;
        bus.uio_in = 8'hA5;
        repeat (2) @(negedge clk);
        check("init_uo", {24'd0, bus.uo_out}, 32'd0);
        check("init_uio", {24'd0, bus.uio_out}, 32'd0);
        check("init_oe", {24'd0, bus.uio_oe}, 32'hFF);

        do_reset("n51", 8'd51);
        measure("n51", 24, 1'b0);

        do_reset("n1", 8'd1);
        measure("n1", 0, 1'b0);

        do_reset("n0", 8'd0);
        measure("n0", 0, 1'b0);

        do_reset("n27", 8'd27);
        measure("n27", 111, 1'b0);

        do_reset("n231", 8'd231);
        measure("n231", 127, 1'b0);

        do_reset("n255", 8'd255);
        bus.uio_in = 8'h3C;
        measure("n255", 47, 1'b0);

        // Abort after ten edges of the run (count is 9 at that point).
        do_reset("abort51", 8'd51);
        repeat (10) @(negedge clk);
        check("abort_busy", {24'd0, bus.uo_out}, 32'd1);
        check("abort_count", {24'd0, bus.uio_out}, 32'd9);
        do_reset("abort6", 8'd6);
        measure("abort6", 8, 1'b0);

        do_reset("tog51", 8'd51);
        measure("tog51", 24, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
